multi_word_ram_stream_reader: RTL and testbench



---
 rtl/multi_word_ram_stream_reader_if.sv | 28 ++
 rtl/multi_word_ram_stream_reader.sv | 161 ++++++++++++++++
 tb/tb_multi_word_ram_stream_reader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_word_ram_stream_reader_if.sv
// Bus bundle for multi_word_ram_stream_reader.
// Carries the RAM read port (address, enable, row data) and the word-serial
// output stream (data, valid, ready, last).
//   master : the reader; drives ram_addr/ram_rd_en and the stream outputs
//   slave  : RAM plus downstream consumer; drives ram_rd_data and o_ready
interface multi_word_ram_stream_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int NUM_WORDS  = 4
);
   logic [$clog2(DEPTH)-1:0]          ram_addr;
   logic                              ram_rd_en;
   logic [DATA_WIDTH*NUM_WORDS-1:0]   ram_rd_data;
   logic [DATA_WIDTH-1:0]             o_data;
   logic                              o_valid;
   logic                              o_ready;
   logic                              o_last;

   modport master (
      output ram_addr, ram_rd_en, o_data, o_valid, o_last,
      input  ram_rd_data, o_ready
   );

   modport slave (
      input  ram_addr, ram_rd_en, o_data, o_valid, o_last,
      output ram_rd_data, o_ready
   );
endinterface

// File: rtl/multi_word_ram_stream_reader.sv
// Read-side controller for a multi-word block RAM. Fetches num_rows
// consecutive rows starting at base_addr (wrapping at DEPTH-1) and unpacks
// each row into a word-serial valid/ready stream, word 0 first. A row FIFO
// of RAM_LATENCY+1 entries hides the RAM read latency so the stream can run
// at one word per cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               command strobe, honoured only when idle
//   base_addr, num_rows command: first row and row count (0 allowed)
//   busy, done          busy while fetching/draining; one-cycle done pulse
//   bus                 RAM read port and output stream (master modport)
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | issuing row reads, throttled by FIFO space
// DRAIN  | all reads issued, streaming out remaining words
// FINISH | one-cycle done pulse
module multi_word_ram_stream_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 64,
   parameter int NUM_WORDS   = 4,
   parameter int RAM_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(DEPTH)-1:0]     base_addr,
   input  logic [$clog2(DEPTH):0]       num_rows,
   output logic                         busy,
   output logic                         done,
   multi_word_ram_stream_reader_if.master bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int RW  = DATA_WIDTH * NUM_WORDS;
   localparam int FD  = RAM_LATENCY + 1;
   localparam int PW  = $clog2(FD);
   localparam int CW  = $clog2(2 * FD);
   localparam int WIW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam logic [AW:0] ONE_ROW = 1;

   logic [1:0]             state;
   logic [AW-1:0]          addr;
   logic [AW:0]            issue_left;
   logic [AW:0]            pop_left;
   logic [RAM_LATENCY-1:0] dl;
   logic [RW-1:0]          fifo_mem [FD];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          fifo_cnt;
   logic [WIW-1:0]         word_idx;

   logic                   valid;
   logic                   hs;
   logic                   last_word;
   logic                   last_out;
   logic                   push;
   logic                   pop;
   logic                   issue;
   logic [CW-1:0]          inflight;
   logic [CW-1:0]          occ;
   logic [RW-1:0]          head_row;
   logic [DATA_WIDTH-1:0]  word_sel;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + CW'(dl[i]);
   end

   assign valid     = (fifo_cnt != '0);
   assign hs        = valid & bus.o_ready;
   assign last_word = (int'(word_idx) == NUM_WORDS - 1);
   assign pop       = hs & last_word;
   assign push      = dl[RAM_LATENCY-1];
   assign last_out  = valid & last_word & (pop_left == ONE_ROW);

   // A row leaving the FIFO this cycle frees its slot for a read issued in
   // the same cycle; without this credit NUM_WORDS=1 would bubble.
   assign occ   = inflight + fifo_cnt - CW'(pop);
   assign issue = (state == S_FETCH) && (occ < CW'(FD));

   assign head_row = fifo_mem[rd_ptr];
   always_comb begin
      word_sel = '0;
      for (int i = 0; i < NUM_WORDS; i++)
         if (int'(word_idx) == i) word_sel = head_row[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign bus.o_valid   = valid;
   assign bus.o_data    = valid ? word_sel : '0;
   assign bus.o_last    = last_out;
   assign bus.ram_rd_en = issue;
   assign bus.ram_addr  = addr;
   assign busy          = (state == S_FETCH) || (state == S_DRAIN);
   assign done          = (state == S_FINISH);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.ram_rd_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         issue_left <= '0;
         pop_left   <= '0;
         dl         <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         word_idx   <= '0;
      end else begin
         dl <= RAM_LATENCY'({dl, issue});

         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) begin
            rd_ptr   <= ptr_inc(rd_ptr);
            pop_left <= pop_left - 1'b1;
         end
         if (hs) word_idx <= last_word ? '0 : word_idx + 1'b1;

         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (issue) begin
            addr       <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
            issue_left <= issue_left - 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  addr       <= base_addr;
                  issue_left <= num_rows;
                  pop_left   <= num_rows;
                  state      <= (num_rows == '0) ? S_FINISH : S_FETCH;
               end
            end
            S_FETCH: begin
               if (issue && issue_left == ONE_ROW) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (hs && last_out) state <= S_FINISH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multi_word_ram_stream_reader.sv
module tb_multi_word_ram_stream_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_a, start_b;
   logic [5:0] base_a, base_b;
   logic [6:0] rows_a, rows_b;
   logic       busy_a, done_a, busy_b, done_b;

   multi_word_ram_stream_reader_if #(.DATA_WIDTH(8), .DEPTH(64), .NUM_WORDS(4)) ifa ();
   multi_word_ram_stream_reader_if #(.DATA_WIDTH(8), .DEPTH(64), .NUM_WORDS(1)) ifb ();

   multi_word_ram_stream_reader #(.DATA_WIDTH(8), .DEPTH(64), .NUM_WORDS(4), .RAM_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a), .num_rows(rows_a),
      .busy(busy_a), .done(done_a), .bus(ifa)
   );

   multi_word_ram_stream_reader #(.DATA_WIDTH(8), .DEPTH(64), .NUM_WORDS(1), .RAM_LATENCY(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .num_rows(rows_b),
      .busy(busy_b), .done(done_b), .bus(ifb)
   );

   // RAM models: A has 1-cycle latency, B has an output register (2 cycles).
   logic [31:0] mem_a [64];
   logic [7:0]  mem_b [64];
   logic [7:0]  rb1;

   always @(posedge clk) if (ifa.ram_rd_en) ifa.ram_rd_data <= mem_a[ifa.ram_addr];
   always @(posedge clk) begin
      if (ifb.ram_rd_en) rb1 <= mem_b[ifb.ram_addr];
      ifb.ram_rd_data <= rb1;
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_word(input int sel, input int base, input int w);
      int row;
      if (sel == 0) begin
         row = (base + w / 4) % 64;
         return 8'(row * 4 + w % 4);
      end
      row = (base + w) % 64;
      return 8'(row * 3 + 1);
   endfunction

   typedef struct {
      int base;
      int rows;
      int rmode;   // 0: ready always 1, 1: pseudo-random ready
      int words;
      int first;
      int last;
      int lat;
      int glitch;  // cycle offset of a stray start strobe, 0 = none
   } vec_t;

   vec_t vecs [6];

   task automatic set_ready(input int sel, input logic r);
      if (sel == 0) ifa.o_ready = r; else ifb.o_ready = r;
   endtask

   task automatic run_cmd(input int sel, input int base, input int rows, input int rmode,
                          input int exp_words, input int exp_first, input int exp_last,
                          input int exp_lat, input int glitch_k);
      logic v, r, l, en, bz, dn, prev_l, stall_prev;
      logic [7:0] d, ad, prev_d, first_d, last_d;
      int nw, lat, issued, popped, nwords, first_v, last_k, done_k, done_cnt;
      int max_out, busy_err, out;
      nw = (sel == 0) ? 4 : 1;
      lat = (sel == 0) ? 1 : 2;
      issued = 0; popped = 0; nwords = 0; first_v = -1; last_k = -1; done_k = -1;
      done_cnt = 0; max_out = 0; busy_err = 0; stall_prev = 1'b0;
      prev_d = '0; prev_l = 1'b0; first_d = '0; last_d = '0;

      @(posedge clk); #1;
      if (sel == 0) begin start_a = 1'b1; base_a = 6'(base); rows_a = 7'(rows); end
      else begin start_b = 1'b1; base_b = 6'(base); rows_b = 7'(rows); end
      set_ready(sel, 1'b1);
      @(negedge clk);
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         start_a = 1'b0; start_b = 1'b0;
         if (glitch_k == k) begin
            if (sel == 0) begin start_a = 1'b1; base_a = 6'd40; rows_a = 7'd5; end
            else begin start_b = 1'b1; base_b = 6'd40; rows_b = 7'd5; end
         end
         set_ready(sel, (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
         @(negedge clk);
         if (sel == 0) begin
            v = ifa.o_valid; r = ifa.o_ready; d = ifa.o_data; l = ifa.o_last;
            en = ifa.ram_rd_en; ad = 8'(ifa.ram_addr); bz = busy_a; dn = done_a;
         end else begin
            v = ifb.o_valid; r = ifb.o_ready; d = ifb.o_data; l = ifb.o_last;
            en = ifb.ram_rd_en; ad = 8'(ifb.ram_addr); bz = busy_b; dn = done_b;
         end
         if (bz !== ((rows != 0) && done_k < 0 && !dn)) busy_err++;
         if (v && first_v < 0) first_v = k;
         if (stall_prev) chk("stall_hold", {22'd0, v, l, d}, {22'd0, 1'b1, prev_l, prev_d});
         if (en) begin
            chk("ram_addr", 32'(ad), 32'((base + issued) % 64));
            issued++;
         end
         if (v && r) begin
            chk("word", 32'(d), 32'(exp_word(sel, base, nwords)));
            chk("o_last", 32'(l), 32'(nwords == exp_words - 1));
            if (nwords == 0) first_d = d;
            if (l) begin last_k = k; last_d = d; end
            if (nwords % nw == nw - 1) popped++;
            nwords++;
         end
         out = issued - popped;
         if (out > max_out) max_out = out;
         if (dn) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         stall_prev = v & ~r;
         prev_d = d;
         prev_l = l;
         if (done_k >= 0 && k >= done_k + 3) break;
      end
      set_ready(sel, 1'b1);
      chk("done_seen", 32'(done_k >= 0), 32'd1);
      chk("done_count", done_cnt, 1);
      chk("word_count", nwords, exp_words);
      chk("reads_issued", issued, rows);
      chk("busy_profile", busy_err, 0);
      chk("row_fifo_bound", 32'(max_out <= lat + 1), 32'd1);
      if (exp_words == 0) begin
         chk("zero_no_valid", first_v, -1);
         chk("zero_done_at_1", done_k, 1);
      end else begin
         chk("first_valid_lat", first_v, exp_lat);
         chk("first_word", 32'(first_d), exp_first);
         chk("last_word", 32'(last_d), exp_last);
         chk("done_after_last", done_k, last_k + 1);
         if (rmode == 0) chk("no_bubbles", last_k - first_v, exp_words - 1);
      end
   endtask

   initial begin
      int bad;
      for (int r = 0; r < 64; r++) begin
         mem_a[r] = {8'(4*r+3), 8'(4*r+2), 8'(4*r+1), 8'(4*r)};
         mem_b[r] = 8'(r*3+1);
      end
      vecs[0] = '{0,  3,  0, 12,  'h00, 'h0B, 3, 0};
      vecs[1] = '{0,  3,  1, 12,  'h00, 'h0B, 3, 0};
      vecs[2] = '{62, 4,  0, 16,  'hF8, 'h07, 3, 0};
      vecs[3] = '{10, 3,  1, 12,  'h28, 'h33, 3, 3};
      vecs[4] = '{0,  0,  0, 0,   'h00, 'h00, 0, 0};
      vecs[5] = '{63, 64, 0, 256, 'hFC, 'hFB, 3, 0};

      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      base_a = '0; base_b = '0; rows_a = '0; rows_b = '0;
      ifa.o_ready = 1'b1; ifb.o_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy_a",  32'(busy_a), 0);
      chk("rst_done_a",  32'(done_a), 0);
      chk("rst_rd_en_a", 32'(ifa.ram_rd_en), 0);
      chk("rst_addr_a",  32'(ifa.ram_addr), 0);
      chk("rst_valid_a", 32'(ifa.o_valid), 0);
      chk("rst_data_a",  32'(ifa.o_data), 0);
      chk("rst_last_a",  32'(ifa.o_last), 0);
      chk("rst_busy_b",  32'(busy_b), 0);
      chk("rst_done_b",  32'(done_b), 0);
      chk("rst_valid_b", 32'(ifb.o_valid), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Reset while draining: stream stalled, both rows already fetched.
      start_a = 1'b1; base_a = 6'd0; rows_a = 7'd2; ifa.o_ready = 1'b0;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("drain_busy",  32'(busy_a), 1);
      chk("drain_valid", 32'(ifa.o_valid), 1);
      chk("drain_rd_en", 32'(ifa.ram_rd_en), 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_outputs",
          {25'd0, busy_a, done_a, ifa.ram_rd_en, ifa.o_valid, ifa.o_last, 2'b00},
          32'd0);
      chk("abort_addr_data", {18'd0, 6'(ifa.ram_addr), ifa.o_data}, 32'd0);
      ifa.o_ready = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done_a || ifa.o_valid || ifa.ram_rd_en || busy_a) bad++;
      end
      chk("abort_quiet", bad, 0);

      for (int i = 0; i < 6; i++)
         run_cmd(0, vecs[i].base, vecs[i].rows, vecs[i].rmode, vecs[i].words,
                 vecs[i].first, vecs[i].last, vecs[i].lat, vecs[i].glitch);

      // Latency-2 RAM with one word per row: back-to-back words, then stalls.
      run_cmd(1, 5,  8, 0, 8, 'h10, 'h25, 4, 0);
      run_cmd(1, 60, 6, 1, 6, 'hB5, 'h04, 4, 2);
      run_cmd(1, 0,  0, 0, 0, 'h00, 'h00, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
